// File: rtl/clkgen_multimode.sv
// clkgen_multimode: FAST/DIV/STEP/HALT clock generator with glitch-free low-phase commits.
// Optional macro CLKGEN_TICK_COUNT_EN adds the tick_count output.
module clkgen_multimode #(
  parameter int CNT_W       = 25,
  parameter int DEFAULT_DIV = 500
) (
  input  logic             inclk,
  input  logic             reset,
  input  logic [1:0]       mode_sel,
  input  logic [CNT_W-1:0] div_val,
  input  logic             step_req,
  output logic             outclk,
  output logic             tick,
`ifdef CLKGEN_TICK_COUNT_EN
  output logic [CNT_W-1:0] tick_count,
`endif
  output logic [1:0]       mode_active
);
  typedef enum logic [1:0] {FAST = 2'b00, DIV = 2'b01, STEP = 2'b10, HALT = 2'b11} mode_t;
  mode_t            r_mode, w_mode;
  logic             r_outclk, r_tick, r_s1, r_s2, r_s3;
  logic             w_commit, w_hit, w_edge, w_outclk, w_tick;
  logic [CNT_W-1:0] r_count, r_div, w_div, w_count;
  // New mode/divisor only take effect at the start of a low phase, so no runt pulses
  always_comb begin
    w_commit = ~r_outclk && (r_count == '0);
    w_mode   = w_commit ? mode_t'(mode_sel) : r_mode;
    w_div    = w_commit ? div_val : r_div;
    w_hit    = r_count == w_div;
    w_edge   = r_s2 & ~r_s3;
    w_outclk = 1'b0;
    w_count  = '0;
    case (w_mode)
      FAST: w_outclk = ~r_outclk;
      DIV: begin
        w_outclk = r_outclk ^ w_hit;
        w_count  = w_hit ? '0 : r_count + 1'b1;
      end
      STEP: begin
        w_outclk = r_outclk ? ~w_hit : w_edge;
        w_count  = (r_outclk && !w_hit) ? r_count + 1'b1 : '0;
      end
      default: w_outclk = 1'b0;
    endcase
    w_tick = w_outclk & ~r_outclk;
  end
  always_ff @(posedge inclk) begin
    if (reset) begin
      r_outclk <= 1'b0;
      r_tick   <= 1'b0;
      r_count  <= '0;
      r_mode   <= HALT;
      r_div    <= CNT_W'(DEFAULT_DIV);
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_s3     <= 1'b0;
    end else begin
      r_outclk <= w_outclk;
      r_tick   <= w_tick;
      r_count  <= w_count;
      r_mode   <= w_mode;
      r_div    <= w_div;
      r_s1     <= step_req;
      r_s2     <= r_s1;
      r_s3     <= r_s2;
    end
  end
`ifdef CLKGEN_TICK_COUNT_EN
  logic [CNT_W-1:0] r_tick_count;
  always_ff @(posedge inclk) begin
    if (reset) r_tick_count <= '0;
    else if (r_tick) r_tick_count <= r_tick_count + 1'b1;
  end
  assign tick_count = r_tick_count;
`endif
  assign outclk      = r_outclk;
  assign tick        = r_tick;
  assign mode_active = r_mode;
endmodule

// File: tb/tb_clkgen_multimode.sv
// tb_clkgen_multimode: table vectors, directed corner sequences and random stimulus vs a phase model.
module tb_clkgen_multimode;
  localparam int W = 10;
  localparam int DEF = 500;
  logic          inclk, reset, step_req, outclk, tick;
  logic [1:0]    mode_sel, mode_active;
  logic [W-1:0]  div_val;
`ifdef CLKGEN_TICK_COUNT_EN
  logic [W-1:0]  tick_count;
`endif
  int vectors = 0, miscompares = 0;
  clkgen_multimode #(.CNT_W(W), .DEFAULT_DIV(DEF)) dut (
    .inclk(inclk), .reset(reset), .mode_sel(mode_sel), .div_val(div_val),
    .step_req(step_req), .outclk(outclk), .tick(tick),
`ifdef CLKGEN_TICK_COUNT_EN
    .tick_count(tick_count),
`endif
    .mode_active(mode_active));
  initial inclk = 1'b0;
  always #5 inclk = ~inclk;
  // Model: phases counted down from their length; m_start marks the first cycle of a phase
  bit m_out = 0, m_tick = 0, m_start = 1;
  int m_rem = 0, m_mode = 3, m_div = DEF, m_tc = 0;
  bit [2:0] m_h = 0;
  task automatic model_step();
    bit e, n;
    if (reset) begin
      m_out = 0; m_tick = 0; m_start = 1; m_rem = 0; m_mode = 3; m_div = DEF; m_tc = 0; m_h = 0;
    end else begin
      e = m_h[1] & ~m_h[2];
      m_h = {m_h[1:0], step_req};
      if (!m_out && m_start) begin
        m_mode = mode_sel;
        m_div  = div_val;
      end
      n = 0;
      if (m_mode == 0) begin
        n = !m_out; m_start = 1;
      end else if (m_mode == 1 || (m_mode == 2 && m_out)) begin
        if (m_start) m_rem = m_div;
        if (m_rem == 0) begin
          n = (m_mode == 1) ? !m_out : 1'b0; m_start = 1;
        end else begin
          n = m_out; m_rem--; m_start = 0;
        end
      end else if (m_mode == 2) begin
        n = e; m_start = 1;
      end else begin
        n = 0; m_start = 1;
      end
      if (m_tick) m_tc = (m_tc + 1) % (1 << W);
      m_tick = n & !m_out;
      m_out  = n;
    end
  endtask
  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic cycle();
    @(posedge inclk);
    #1;
    model_step();
    check("model outclk", outclk, m_out);
    check("model tick", tick, m_tick);
    check("model mode_active", mode_active, m_mode);
`ifdef CLKGEN_TICK_COUNT_EN
    check("model tick_count", tick_count, m_tc);
`endif
  endtask
  task automatic do_reset(logic [1:0] m, logic [W-1:0] d);
    reset = 1; mode_sel = m; div_val = d; step_req = 0;
    cycle();
    reset = 0;
  endtask
  task automatic measure(string nm, logic v, int exp);
    int n = 0;
    while (outclk === v && n < 64) begin
      n++;
      cycle();
    end
    check(nm, n, exp);
  endtask
  typedef struct {
    logic rst; logic [1:0] mode; logic [W-1:0] div; logic st;
    logic eo; logic et; logic [1:0] em;
  } vec_t;
  vec_t tbl[13];
  initial begin
    int rises, highs, n;
    bit prev;
    tbl[0] = '{rst: 1, mode: 1, div: 3, st: 0, eo: 0, et: 0, em: 3};
    for (int i = 1; i < 13; i++)
      tbl[i] = '{rst: 0, mode: 1, div: 3, st: 0, eo: ((i / 4) % 2 == 1), et: (i % 8 == 4), em: 1};
    reset = 1; mode_sel = 0; div_val = 0; step_req = 0;
    for (int i = 0; i < 13; i++) begin
      reset = tbl[i].rst; mode_sel = tbl[i].mode; div_val = tbl[i].div; step_req = tbl[i].st;
      cycle();
      check($sformatf("tbl[%0d] outclk", i), outclk, tbl[i].eo);
      check($sformatf("tbl[%0d] tick", i), tick, tbl[i].et);
      check($sformatf("tbl[%0d] mode_active", i), mode_active, tbl[i].em);
    end
    // divisor change while high: current high keeps 4, then 10/10
    div_val = 9;
    measure("div3 high before change", 1, 4);
    measure("div9 low", 0, 10);
    measure("div9 high", 1, 10);
    // FAST then HALT while high
    do_reset(0, 0);
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      cycle();
      check("fast toggle", outclk, i % 2);
      n += tick;
    end
    check("fast tick count", n, 4);
    cycle();
    check("fast high before halt", outclk, 1);
    mode_sel = 3;
    cycle();
    check("halt first low", outclk, 0);
    cycle();
    check("halt committed", mode_active, 3);
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("halt outclk", outclk, 0);
      check("halt tick", tick, 0);
    end
    // STEP with step_req held 20 cycles
    do_reset(2, 2);
    cycle();
    check("step committed", mode_active, 2);
    step_req = 1;
    prev = 0; rises = 0; highs = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (i == 2) check("step before rise", outclk, 0);
      if (i == 3) check("step rise at 3rd edge", outclk, 1);
      if (i == 3) check("step tick at rise", tick, 1);
      if (outclk && !prev) rises++;
      highs += outclk;
      prev = outclk;
    end
    check("step held pulses", rises, 1);
    check("step high cycles", highs, 3);
    step_req = 0;
    repeat (4) cycle();
    // second rising edge arriving during the pulse
    prev = 0; rises = 0;
    for (int i = 0; i < 14; i++) begin
      step_req = (i == 0 || (i >= 2 && i < 8));
      cycle();
      if (outclk && !prev) rises++;
      prev = outclk;
    end
    check("step re-edge pulses", rises, 1);
    // reset mid high phase
    do_reset(1, 5);
    n = 0;
    while (outclk !== 1 && n < 40) begin
      n++;
      cycle();
    end
    check("wait div5 high", outclk, 1);
    cycle();
    reset = 1;
    cycle();
    check("reset outclk", outclk, 0);
    check("reset tick", tick, 0);
    check("reset mode_active", mode_active, 3);
    reset = 0; mode_sel = 3;
    cycle();
`ifdef CLKGEN_TICK_COUNT_EN
    do_reset(0, 0);
    repeat (20) cycle();
    check("tick_count 10", tick_count, 10);
    n = 0;
    while (m_tc != (1 << W) - 1 && n < 3000) begin
      n++;
      cycle();
    end
    while (m_tc != 0 && n < 3000) begin
      n++;
      cycle();
    end
    check("tick_count wrap bound", n < 3000, 1);
    check("tick_count wrap", tick_count, 0);
`endif
    // random stimulus against the model
    reset = 1;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 7) == 0) mode_sel = 2'($urandom);
      if ($urandom_range(0, 9) == 0) div_val = W'($urandom_range(0, 6));
      if ($urandom_range(0, 5) == 0) step_req = ~step_req;
      reset = (i == 0) || ($urandom_range(0, 199) == 0);
      cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
